// File: rtl/mdio_master_ctrl.sv
// MDIO (clause 22) management master: one 64-bit read or write frame per request.
// MDC is derived from clk_rmii with CLK_DIV cycles per half-period.
module mdio_master_ctrl #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk_rmii,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        o_mdc,
  output logic        o_mdio,
  output logic        oe_mdio,
  input  logic        i_mdio
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_idx;
  logic [63:0] frame;
  logic [63:0] req_frame;
  logic        wr_q;
  logic [1:0]  sync;
  logic [14:0] rd_sh;
  logic        ta_err;
  logic        ph_end;
  logic        smp;

  // read frames carry all-ones in TA/DATA so o_mdio idles high
  always_comb begin
    req_frame = {32'hFFFF_FFFF, 2'b01,
                 req_write ? 2'b01 : 2'b10,
                 req_phy, req_reg,
                 req_write ? {2'b10, req_wdata} : 18'h3FFFF};
  end

  assign ph_end = (div_cnt == DIV_LAST);
  assign smp    = ph_end & o_mdc & ~wr_q;

  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
      o_mdc     <= 1'b0;
      o_mdio    <= 1'b1;
      oe_mdio   <= 1'b0;
      sync      <= 2'b00;
      div_cnt   <= 8'd0;
      bit_idx   <= 6'd0;
      frame     <= '1;
      wr_q      <= 1'b0;
      rd_sh     <= 15'h0000;
      ta_err    <= 1'b0;
    end else begin
      sync      <= {sync[0], i_mdio};
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SHIFT;
            req_ready <= 1'b0;
            div_cnt   <= 8'd0;
            bit_idx   <= 6'd0;
            wr_q      <= req_write;
            o_mdc     <= 1'b0;
            o_mdio    <= req_frame[63];
            frame     <= {req_frame[62:0], 1'b1};
            oe_mdio   <= 1'b1;
          end
        end
        SHIFT: begin
          if (smp && bit_idx == 6'd47)
            ta_err <= sync[1];
          if (smp && bit_idx >= 6'd48)
            rd_sh <= {rd_sh[13:0], sync[1]};
          if (!ph_end) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!o_mdc) begin
              o_mdc <= 1'b1;
            end else if (bit_idx == 6'd63) begin
              state     <= DONE;
              o_mdc     <= 1'b0;
              oe_mdio   <= 1'b0;
              o_mdio    <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= ~wr_q & ta_err;
              if (!wr_q)
                rsp_rdata <= {rd_sh, sync[1]};
            end else begin
              bit_idx <= bit_idx + 6'd1;
              o_mdc   <= 1'b0;
              o_mdio  <= frame[63];
              frame   <= {frame[62:0], 1'b1};
              oe_mdio <= wr_q | (bit_idx < 6'd45);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Bench for mdio_master_ctrl: table of frames plus reset, back-to-back
// and CLK_DIV=2 sequences; responses checked through a scoreboard queue.
module tb_mdio_master_ctrl;

  logic        clk_rmii = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_phy = 5'd0;
  logic [4:0]  req_reg = 5'd0;
  logic [15:0] req_wdata = 16'h0;
  logic        i_mdio = 1'b1;
  logic        sel2 = 1'b0;

  logic        ready_a, rv_a, err_a, mdc_a, mdio_a, oe_a;
  logic        ready_b, rv_b, err_b, mdc_b, mdio_b, oe_b;
  logic [15:0] rd_a, rd_b;

  wire valid_a = req_valid & ~sel2;
  wire valid_b = req_valid & sel2;

  wire        ready_m = sel2 ? ready_b : ready_a;
  wire        rv_m    = sel2 ? rv_b : rv_a;
  wire        err_m   = sel2 ? err_b : err_a;
  wire        mdc_m   = sel2 ? mdc_b : mdc_a;
  wire        mdio_m  = sel2 ? mdio_b : mdio_a;
  wire        oe_m    = sel2 ? oe_b : oe_a;
  wire [15:0] rd_m    = sel2 ? rd_b : rd_a;

  always #5 clk_rmii = ~clk_rmii;

  int cyc = 0;
  always @(posedge clk_rmii) cyc <= cyc + 1;

  mdio_master_ctrl #(.CLK_DIV(10)) dut_a (
    .clk_rmii (clk_rmii),
    .rstn     (rstn),
    .req_valid(valid_a),
    .req_ready(ready_a),
    .req_write(req_write),
    .req_phy  (req_phy),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rv_a),
    .rsp_rdata(rd_a),
    .rsp_err  (err_a),
    .o_mdc    (mdc_a),
    .o_mdio   (mdio_a),
    .oe_mdio  (oe_a),
    .i_mdio   (i_mdio)
  );

  mdio_master_ctrl #(.CLK_DIV(2)) dut_b (
    .clk_rmii (clk_rmii),
    .rstn     (rstn),
    .req_valid(valid_b),
    .req_ready(ready_b),
    .req_write(req_write),
    .req_phy  (req_phy),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rv_b),
    .rsp_rdata(rd_b),
    .rsp_err  (err_b),
    .o_mdc    (mdc_b),
    .o_mdio   (mdio_b),
    .oe_mdio  (oe_b),
    .i_mdio   (i_mdio)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        phy_on;
    logic        ta;
    logic [15:0] pdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives the request and follows the frame to DONE.
  task automatic run_frame(input vec_t v, input int d, input bit hold,
                           output int t_acc);
    logic [63:0] fr;
    exp_t e;
    exp_t g;
    int mdc_bad = 0;
    int mdio_bad = 0;
    int oe_bad = 0;
    int rdy_bad = 0;
    int k;
    bit seen = 0;
    fr = {32'hFFFF_FFFF, 2'b01, v.wr ? 2'b01 : 2'b10, v.phy, v.rg,
          v.wr ? {2'b10, v.wdata} : 18'h3FFFF};
    req_valid = 1'b1;
    req_write = v.wr;
    req_phy   = v.phy;
    req_reg   = v.rg;
    req_wdata = v.wdata;
    chk("ready_at_req", 32'(ready_m), 1);
    t_acc   = cyc;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.at    = t_acc + 1 + 128 * d;
    sbq.push_back(e);
    for (int rel = 1; rel <= 128 * d + 1; rel++) begin
      @(negedge clk_rmii);
      if (rel == 1 && !hold) req_valid = 1'b0;
      k = (rel - 1) / (2 * d);
      if (rel <= 128 * d) begin
        if (mdc_m !== 1'(((rel - 1) / d) % 2)) mdc_bad++;
        if (mdio_m !== fr[63 - k]) mdio_bad++;
        if (oe_m !== (k < 46 || v.wr)) oe_bad++;
        if ((rel - 1) % (2 * d) == 0)
          i_mdio = (v.phy_on && k == 47) ? v.ta :
                   (v.phy_on && k >= 48) ? v.pdata[63 - k] : 1'b1;
      end else begin
        if (mdc_m !== 1'b0) mdc_bad++;
        if (mdio_m !== 1'b1) mdio_bad++;
        if (oe_m !== 1'b0) oe_bad++;
      end
      if (ready_m !== 1'b0) rdy_bad++;
      if (rv_m === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          g = sbq.pop_front();
          chk("rsp_rdata", 32'(rd_m), 32'(g.rdata));
          chk("rsp_err", 32'(err_m), 32'(g.err));
          chk("rsp_cycle", cyc, g.at);
          seen = 1;
        end
      end
    end
    i_mdio = 1'b1;
    if (!seen) chk("rsp_timeout", 0, 1);
    chk("mdc_wave", mdc_bad, 0);
    chk("mdio_bits", mdio_bad, 0);
    chk("oe_bits", oe_bad, 0);
    chk("ready_low", rdy_bad, 0);
    @(negedge clk_rmii);
    chk("ready_after", 32'(ready_m), 1);
    chk("valid_one_cycle", 32'(rv_m), 0);
    chk("idle_lines", {29'd0, mdc_m, mdio_m, oe_m}, 32'b010);
  endtask

  initial begin
    int t1;
    int t2;
    int bad;
    vec_t v;
    tbl[0] = '{1'b1, 5'd1, 5'd0, 16'h1200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd1, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h796D, 16'h796D, 1'b0};
    tbl[2] = '{1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    tbl[3] = '{1'b1, 5'd31, 5'd31, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    tbl[4] = '{1'b0, 5'd16, 5'd21, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1};
    tbl[5] = '{1'b0, 5'd2, 5'd31, 16'h0000, 1'b1, 1'b0, 16'h8001, 16'h8001, 1'b0};

    repeat (3) @(negedge clk_rmii);
    chk("rst_ready", 32'(ready_a), 1);
    chk("rst_valid", 32'(rv_a), 0);
    chk("rst_rdata", 32'(rd_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_lines", {29'd0, mdc_a, mdio_a, oe_a}, 32'b010);
    chk("rst_b", {28'd0, ready_b, mdc_b, mdio_b, oe_b}, 32'b1010);
    rstn = 1'b1;
    @(negedge clk_rmii);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], 10, 1'b0, t1);

    // back-to-back with req_valid held high
    run_frame(tbl[1], 10, 1'b1, t1);
    v = tbl[3];
    v.exp_rdata = 16'h796D;
    run_frame(v, 10, 1'b0, t2);
    chk("b2b_accept", t2, t1 + 2 + 128 * 10);

    // reset pulse in the middle of bit 40 of a read
    req_valid = 1'b1;
    req_write = 1'b0;
    req_phy   = 5'd1;
    req_reg   = 5'd2;
    @(negedge clk_rmii);
    req_valid = 1'b0;
    repeat (80 * 10 + 4) @(negedge clk_rmii);
    rstn = 1'b0;
    @(negedge clk_rmii);
    rstn = 1'b1;
    chk("abort_ready", 32'(ready_a), 1);
    chk("abort_valid", 32'(rv_a), 0);
    chk("abort_rdata", 32'(rd_a), 0);
    chk("abort_err", 32'(err_a), 0);
    chk("abort_lines", {29'd0, mdc_a, mdio_a, oe_a}, 32'b010);
    bad = 0;
    repeat (1400) begin
      @(negedge clk_rmii);
      if (rv_a !== 1'b0) bad++;
    end
    chk("abort_no_rsp", bad, 0);
    run_frame(tbl[1], 10, 1'b0, t1);

    // CLK_DIV=2 instance
    sel2 = 1'b1;
    @(negedge clk_rmii);
    run_frame(tbl[1], 2, 1'b0, t1);
    v = tbl[0];
    v.exp_rdata = 16'h796D;
    run_frame(v, 2, 1'b0, t1);
    run_frame(tbl[2], 2, 1'b0, t1);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
